// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master, one-slave arbiter for the picorv32 native memory bus.
//   Master 0 is normally the core and master 1 a secondary bus master. The
//   granted master's request is forwarded to the slave unchanged, and the
//   slave's completion goes back to that master in the same cycle. A watchdog
//   forces completion of a slave transaction that never returns ready.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin on ties, 1 = master 0 always wins ties
//   TIMEOUT    : BUSY cycles allowed before forced completion, 0 = no watchdog
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   mX_valid/instr/addr/wdata/wstrb : master X request (held until mX_ready)
//   mX_ready, mX_rdata  : completion strobe and read data to master X
//   s_valid/instr/addr/wdata/wstrb  : request to the slave (zero when idle)
//   s_ready, s_rdata    : slave completion and read data
//   grant               : one-hot owner (bit0 = m0, bit1 = m1), 0 = idle
//   timeout_err         : one-cycle pulse on a watchdog-forced completion
module mem_bus_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_grant;
    logic            r_last;     // index of the last master served
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [1:0]      w_grant_nxt;
    logic            w_last_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    logic            w_busy;
    logic            w_sel;      // granted master index
    logic            w_pick;     // master to grant when leaving IDLE
    logic            w_tmo;
    logic            w_done;

    // Outputs are forced quiet while reset is high, even if the state
    // register still says BUSY in the cycle reset is first seen.
    assign w_busy = (r_state == BUSY) && !reset;
    assign w_sel  = r_grant[1];

    // A real s_ready in the last allowed cycle wins over the watchdog.
    assign w_tmo  = w_busy && !s_ready && (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_done = w_busy && (s_ready || w_tmo);

    // Tie-break: fixed priority picks m0; round-robin picks whoever was
    // not served last. A single requester always wins.
    always_comb begin
        w_pick = 1'b0;
        if (m0_valid && m1_valid)
            w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        else
            w_pick = m1_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                // s_ready is deliberately ignored here.
                if (m0_valid || m1_valid) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick ? 2'b10 : 2'b01;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                // Forced completion is treated exactly like a real one,
                // including the round-robin history update.
                if (s_ready || w_tmo) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = w_sel;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;     // m0 wins the first tie after reset
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Slave side: granted master's fields while BUSY, all zero otherwise.
    assign s_valid = w_busy;
    assign s_instr = w_busy & (w_sel ? m1_instr : m0_instr);
    assign s_addr  = w_busy ? (w_sel ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = w_busy ? (w_sel ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb = w_busy ? (w_sel ? m1_wstrb : m0_wstrb) : 4'h0;

    // Master side: only the granted master sees ready/rdata. A forced
    // completion returns zero data.
    assign m0_ready = w_done && !w_sel;
    assign m1_ready = w_done &&  w_sel;
    assign m0_rdata = (w_busy && !w_sel && !w_tmo) ? s_rdata : 32'h0;
    assign m1_rdata = (w_busy &&  w_sel && !w_tmo) ? s_rdata : 32'h0;

    assign grant       = r_grant;
    assign timeout_err = w_tmo;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Two instances share all inputs:
// u_rr (round-robin) and u_fp (fixed priority), both with TIMEOUT = 8.
module tb_mem_bus_arbiter;

    logic        clk, reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_s_instr, rr_tmo;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
    logic [3:0]  rr_s_wstrb;
    logic [1:0]  rr_grant;

    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_tmo;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic [1:0]  fp_grant;

    int n_tot = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
        .s_valid(rr_s_valid), .s_instr(rr_s_instr), .s_addr(rr_s_addr),
        .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(rr_grant), .timeout_err(rr_tmo)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8)) u_fp (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr),
        .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(fp_grant), .timeout_err(fp_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1ns after the edge and
    // outputs checked after a further settle delay.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 0; s_rdata  = 32'hFFFF_FFFF;

        // ---- reset state ----
        tick(); tick();
        settle();
        chk("rst_s_valid", 32'(rr_s_valid), 0);
        chk("rst_grant",   32'(rr_grant), 0);
        chk("rst_m0_ready", 32'(rr_m0_ready), 0);
        chk("rst_m0_rdata", rr_m0_rdata, 0);
        chk("rst_tmo",     32'(rr_tmo), 0);
        chk("rst_s_addr",  rr_s_addr, 0);

        // ---- single read by m0 ----
        tick();
        reset = 0;
        m0_valid = 1; m0_instr = 1; m0_addr = 32'h100; m0_wstrb = 0;
        m1_addr = 32'h9999; m1_instr = 0;
        settle();
        chk("rd_idle_svalid", 32'(rr_s_valid), 0);
        chk("rd_idle_grant",  32'(rr_grant), 0);
        tick();                                   // BUSY cycle 1
        settle();
        chk("rd_b1_svalid", 32'(rr_s_valid), 1);
        chk("rd_b1_grant",  32'(rr_grant), 32'h1);
        chk("rd_b1_saddr",  rr_s_addr, 32'h100);
        chk("rd_b1_sinstr", 32'(rr_s_instr), 1);
        chk("rd_b1_m0rdy",  32'(rr_m0_ready), 0);
        tick();                                   // BUSY cycle 2, slave done
        s_ready = 1; s_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_b2_svalid", 32'(rr_s_valid), 1);
        chk("rd_b2_m0rdy",  32'(rr_m0_ready), 1);
        chk("rd_b2_m0data", rr_m0_rdata, 32'hDEADBEEF);
        chk("rd_b2_m1rdy",  32'(rr_m1_ready), 0);
        chk("rd_b2_m1data", rr_m1_rdata, 0);
        tick();
        s_ready = 0; m0_valid = 0;
        settle();
        chk("rd_end_svalid", 32'(rr_s_valid), 0);
        chk("rd_end_grant",  32'(rr_grant), 0);
        chk("rd_end_m0rdy",  32'(rr_m0_ready), 0);

        // ---- both masters continuously valid from reset ----
        reset = 1;
        tick();
        reset = 0;
        m0_valid = 1; m0_addr = 32'hA0; m0_instr = 0;
        m1_valid = 1; m1_addr = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("tie%0d_idle_rr", i), 32'(rr_s_valid), 0);
            chk($sformatf("tie%0d_idle_fp", i), 32'(fp_s_valid), 0);
            tick();
            s_ready = 1; s_rdata = 32'h50 + i;
            settle();
            chk($sformatf("tie%0d_rr_grant", i), 32'(rr_grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("tie%0d_rr_saddr", i), rr_s_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
            chk($sformatf("tie%0d_rr_rdy", i), {30'd0, rr_m1_ready, rr_m0_ready},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("tie%0d_fp_grant", i), 32'(fp_grant), 32'h1);
            chk($sformatf("tie%0d_fp_m1rdy", i), 32'(fp_m1_ready), 0);
            chk($sformatf("tie%0d_fp_m0data", i), fp_m0_rdata, 32'h50 + i);
            tick();
            s_ready = 0;
        end
        m0_valid = 0; m1_valid = 0;
        tick();

        // ---- write forwarding from m1 ----
        m0_addr = 32'h4444; m0_wdata = 32'hCAFE; m0_wstrb = 4'hF; m0_instr = 1;
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h2000;
        m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
        tick();
        s_ready = 1; s_rdata = 32'h0;
        settle();
        chk("wr_grant",  32'(rr_grant), 32'h2);
        chk("wr_saddr",  rr_s_addr, 32'h2000);
        chk("wr_swdata", rr_s_wdata, 32'h12345678);
        chk("wr_swstrb", 32'(rr_s_wstrb), 32'h3);
        chk("wr_sinstr", 32'(rr_s_instr), 0);
        chk("wr_m1rdy",  32'(rr_m1_ready), 1);
        chk("wr_m0rdy",  32'(rr_m0_ready), 0);
        tick();
        s_ready = 0; m1_valid = 0;
        settle();
        chk("wr_end_svalid", 32'(rr_s_valid), 0);
        chk("wr_end_swdata", rr_s_wdata, 0);

        // ---- watchdog: slave never ready ----
        m0_valid = 1; m0_addr = 32'h300; m0_wstrb = 0; m0_instr = 0;
        s_rdata = 32'h55AA55AA;
        tick();
        for (int c = 1; c <= 8; c++) begin
            settle();
            chk($sformatf("wd_c%0d_svalid", c), 32'(rr_s_valid), 1);
            chk($sformatf("wd_c%0d_m0rdy", c), 32'(rr_m0_ready), (c == 8) ? 1 : 0);
            chk($sformatf("wd_c%0d_tmo", c), 32'(rr_tmo), (c == 8) ? 1 : 0);
            if (c == 8) chk("wd_c8_m0data", rr_m0_rdata, 0);
            if (c < 8) tick();
        end
        tick();
        m0_valid = 0;
        settle();
        chk("wd_end_svalid", 32'(rr_s_valid), 0);
        chk("wd_end_grant",  32'(rr_grant), 0);
        chk("wd_end_tmo",    32'(rr_tmo), 0);

        // ---- watchdog: s_ready arrives in the 8th cycle ----
        m0_valid = 1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) s_ready = 1;
            settle();
            chk($sformatf("wr8_c%0d_m0rdy", c), 32'(rr_m0_ready), (c == 8) ? 1 : 0);
            chk($sformatf("wr8_c%0d_tmo", c), 32'(rr_tmo), 0);
            if (c == 8) chk("wr8_c8_m0data", rr_m0_rdata, 32'h55AA55AA);
            if (c < 8) tick();
        end
        tick();
        s_ready = 0; m0_valid = 0;
        settle();
        chk("wr8_end_svalid", 32'(rr_s_valid), 0);

        // ---- reset in the 2nd BUSY cycle (last currently = m0) ----
        m0_valid = 1; m0_addr = 32'h700;
        tick();                                   // BUSY 1
        settle();
        chk("rb_b1_grant", 32'(rr_grant), 32'h1);
        tick();                                   // BUSY 2
        reset = 1;
        settle();
        chk("rb_b2_m0rdy", 32'(rr_m0_ready), 0);
        tick();
        reset = 0;
        m1_valid = 1; m1_addr = 32'h800;          // tie in the first IDLE cycle
        settle();
        chk("rb_post_svalid", 32'(rr_s_valid), 0);
        chk("rb_post_grant",  32'(rr_grant), 0);
        chk("rb_post_rdy",    {30'd0, rr_m1_ready, rr_m0_ready}, 0);
        tick();
        s_ready = 1;
        settle();
        chk("rb_tie_grant", 32'(rr_grant), 32'h1);
        chk("rb_tie_m0rdy", 32'(rr_m0_ready), 1);
        tick();
        s_ready = 0; m0_valid = 0; m1_valid = 0;
        tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
